// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit: one shift-add or restoring
// shift-subtract step per clock, with sign correction at the end.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t state, state_next;

   logic [CW-1:0]    count;
   logic             mode_r, sign_a, sign_b;
   logic [WIDTH-1:0] a_r, b_r, opnd, acc, low;

   logic               last_iter, div_by_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] product, product_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign last_iter   = (count == CW'(WIDTH - 1));
   assign div_by_zero = mode_r && (b_r == '0);

   // Magnitudes are unsigned, so negating MIN yields 2^(WIDTH-1) as wanted
   assign a_mag = a_r[WIDTH-1] ? -a_r : a_r;
   assign b_mag = b_r[WIDTH-1] ? -b_r : b_r;

   // acc/low form the running product (multiply) or remainder/quotient (divide)
   assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc, low[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};

   assign product     = {acc, low};
   assign product_fix = (sign_a ^ sign_b) ? -product : product;
   assign quot_fix    = (sign_a ^ sign_b) ? -low : low;
   assign rem_fix     = sign_a ? -acc : acc;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = PREP;
         PREP:    state_next = div_by_zero ? DONE : CALC;
         CALC:    if (last_iter) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         mode_r <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         opnd   <= '0;
         acc    <= '0;
         low    <= '0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r    <= a;
                  b_r    <= b;
                  mode_r <= mode;
                  busy   <= 1'b1;
               end
            end
            PREP: begin
               sign_a <= a_r[WIDTH-1];
               sign_b <= b_r[WIDTH-1];
               count  <= '0;
               acc    <= '0;
               opnd   <= mode_r ? b_mag : a_mag;
               low    <= mode_r ? a_mag : b_mag;
               if (div_by_zero) begin
                  div0 <= 1'b1;
                  done <= 1'b1;
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (!mode_r) begin
                  acc <= mul_sum[WIDTH:1];
                  low <= {mul_sum[0], low[WIDTH-1:1]};
               end else begin
                  acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  low <= {low[WIDTH-2:0], ~div_diff[WIDTH]};
               end
            end
            FIX: begin
               if (!mode_r) begin
                  hi <= product_fix[2*WIDTH-1:WIDTH];
                  lo <= product_fix[WIDTH-1:0];
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
               div0 <= 1'b0;
               done <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, hand-written corner sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, mode = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div0;

   logic        start8 = 1'b0, mode8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  hi8, lo8;
   logic        busy8, done8, div08;

   int tests = 0;
   int failures = 0;

   logic [31:0] model_hi = '0, model_lo = '0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .mode(mode8), .a(a8), .b(b8),
      .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div0(div08)
   );

   typedef struct {
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: signed arithmetic on 64-bit integers, previous result kept on divide-by-zero
   task automatic ref_model(input logic m, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] ehi, output logic [31:0] elo,
                            output logic ediv0, output int elat);
      longint sx, sy, p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ediv0 = 1'b0;
      elat  = 34;
      if (!m) begin
         p   = sx * sy;
         ehi = p[63:32];
         elo = p[31:0];
      end else if (y == 32'd0) begin
         ehi   = model_hi;
         elo   = model_lo;
         ediv0 = 1'b1;
         elat  = 1;
      end else begin
         q   = sx / sy;
         r   = sx % sy;
         ehi = r[31:0];
         elo = q[31:0];
      end
      model_hi = ehi;
      model_lo = elo;
   endtask

   task automatic apply_stimulus(input logic m, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      mode  = m;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output logic [31:0] rhi, output logic [31:0] rlo,
                            output logic rdiv0, output int lat, output logic busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (!busy) busy_ok = 1'b0;
         if (done) break;
      end
      rhi   = hi;
      rlo   = lo;
      rdiv0 = div0;
      @(posedge clk);
      #1;
      check_output("done_one_cycle", {63'd0, done}, 64'd0);
      check_output("busy_after_done", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_and_check(input string name, input logic m, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] ehi, elo, rhi, rlo;
      logic        ediv0, rdiv0, busy_ok;
      int          elat, lat;
      ref_model(m, x, y, ehi, elo, ediv0, elat);
      apply_stimulus(m, x, y);
      wait_done(rhi, rlo, rdiv0, lat, busy_ok);
      check_output({name, "_hilo"}, {rhi, rlo}, {ehi, elo});
      check_output({name, "_div0"}, {63'd0, rdiv0}, {63'd0, ediv0});
      check_output({name, "_latency"}, 64'(lat), 64'(elat));
      check_output({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
   endtask

   initial begin
      logic [31:0] ehi, elo, rhi, rlo, rx, ry;
      logic        ediv0, rdiv0, busy_ok, rm;
      int          elat, lat;

      vecs[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[3] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[6] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[7] = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[8] = '{1'b1, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000};
      vecs[9] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_outputs", {hi, lo}, 64'd0);
      check_output("reset_flags", {61'd0, busy, done, div0}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].m, vecs[i].a, vecs[i].b);
         wait_done(rhi, rlo, rdiv0, lat, busy_ok);
         check_output($sformatf("vec%0d_hilo", i), {rhi, rlo}, {vecs[i].hi, vecs[i].lo});
         check_output($sformatf("vec%0d_div0", i), {63'd0, rdiv0}, 64'd0);
         check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
         check_output($sformatf("vec%0d_busy", i), {63'd0, busy_ok}, 64'd1);
         model_hi = vecs[i].hi;
         model_lo = vecs[i].lo;
      end

      // Divide by zero leaves the previous result in place
      run_and_check("prior_0x451_div_0x20", 1'b1, 32'h00000451, 32'h00000020);
      check_output("prior_value", {hi, lo}, {32'h11, 32'h22});
      run_and_check("div_by_zero", 1'b1, 32'h00000005, 32'h00000000);
      check_output("div0_held_idle", {63'd0, div0}, 64'd1);
      run_and_check("div0_cleared", 1'b0, 32'h00000003, 32'h00000004);

      // Start and operand changes while busy are ignored
      ref_model(1'b0, 32'h00001234, 32'hFFFF0001, ehi, elo, ediv0, elat);
      apply_stimulus(1'b0, 32'h00001234, 32'hFFFF0001);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      a     = 32'h55555555;
      b     = 32'h00000003;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(rhi, rlo, rdiv0, lat, busy_ok);
      check_output("ignore_start_hilo", {rhi, rlo}, {ehi, elo});
      check_output("ignore_start_latency", 64'(lat), 64'(elat - 5));
      check_output("ignore_start_busy", {63'd0, busy_ok}, 64'd1);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         rm = 1'($urandom);
         rx = $urandom;
         ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) ry = 32'($signed(ry) >>> $urandom_range(0, 31));
         run_and_check($sformatf("rand%0d", i), rm, rx, ry);
      end

      // Reset in the middle of an operation
      apply_stimulus(1'b0, 32'h00000009, 32'h00000009);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("midreset_hilo", {hi, lo}, 64'd0);
      check_output("midreset_flags", {61'd0, busy, done, div0}, 64'd0);
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (done) lat++;
      end
      check_output("midreset_no_done", 64'(lat), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      model_hi = '0;
      model_lo = '0;
      run_and_check("after_reset", 1'b1, 32'hFFFFFF9C, 32'h00000007);

      // WIDTH=8 instance
      for (int i = 0; i < 3; i++) begin
         logic [7:0] x8, y8, eh8, el8;
         logic       m8;
         case (i)
            0:       begin m8 = 1'b0; x8 = 8'h7F; y8 = 8'h7F; eh8 = 8'h3F; el8 = 8'h01; end
            1:       begin m8 = 1'b0; x8 = 8'h80; y8 = 8'h80; eh8 = 8'h40; el8 = 8'h00; end
            default: begin m8 = 1'b1; x8 = 8'h80; y8 = 8'hFF; eh8 = 8'h00; el8 = 8'h80; end
         endcase
         @(negedge clk);
         mode8  = m8;
         a8     = x8;
         b8     = y8;
         start8 = 1'b1;
         @(posedge clk);
         #1;
         start8 = 1'b0;
         lat = 0;
         while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (done8) break;
         end
         check_output($sformatf("w8_%0d_hilo", i), {48'd0, hi8, lo8}, {48'd0, eh8, el8});
         check_output($sformatf("w8_%0d_latency", i), 64'(lat), 64'd10);
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
